ysyx_mem_arbiter: RTL and testbench

YSYX_MEM_ARBITER -- requirements
Module: ysyx_mem_arbiter

---
 rtl/ysyx_mem_arbiter_if.sv | 46 ++++
 rtl/ysyx_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_ysyx_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU masters, the arbiter and the single-beat memory port.
// The arbiter takes the slave view; the masters and the memory model take the master view.
interface ysyx_mem_arbiter_if;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic [1:0]  ifu_len;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        ifu_rlast;

  logic        lsu_req;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic [1:0]  lsu_size;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;

  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_respValid;

  modport slave (
    input  ifu_req, ifu_addr, ifu_len,
    output ifu_rvalid, ifu_rdata, ifu_rlast,
    input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_size,
    output lsu_rvalid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    input  mem_rdata, mem_respValid
  );

  modport master (
    output ifu_req, ifu_addr, ifu_len,
    input  ifu_rvalid, ifu_rdata, ifu_rlast,
    output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_size,
    input  lsu_rvalid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    output mem_rdata, mem_respValid
  );
endinterface

// File: rtl/ysyx_mem_arbiter.sv
// Two-master arbiter (IFU burst reader, LSU single access) onto one single-beat memory port.
//   state   | meaning
//   IDLE    | no transaction; requests sampled, round-robin on a tie
//   IFU     | IFU burst in flight, one beat per memory response
//   LSU     | LSU access in flight, completes on the memory response
module ysyx_mem_arbiter (
  input  logic              clock,
  input  logic              reset,
  ysyx_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IFU  = 2'd1,
    ST_LSU  = 2'd2
  } state_t;

  state_t      state;
  logic        last_grant_lsu;
  logic [31:0] ifu_base;
  logic [1:0]  ifu_len_q;
  logic [1:0]  beat;
  logic        lsu_wen_q;
  logic [31:0] lsu_addr_q;
  logic [31:0] lsu_wdata_q;
  logic [3:0]  lsu_wmask_q;
  logic [1:0]  lsu_size_q;

  logic        grant_lsu;
  logic        grant_ifu;

  // On a tie the master that did not win last time gets the port.
  assign grant_lsu = bus.lsu_req && (!bus.ifu_req || !last_grant_lsu);
  assign grant_ifu = bus.ifu_req && !grant_lsu;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      last_grant_lsu <= 1'b0;
      ifu_base       <= 32'd0;
      ifu_len_q      <= 2'd0;
      beat           <= 2'd0;
      lsu_wen_q      <= 1'b0;
      lsu_addr_q     <= 32'd0;
      lsu_wdata_q    <= 32'd0;
      lsu_wmask_q    <= 4'd0;
      lsu_size_q     <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_lsu) begin
            lsu_wen_q      <= bus.lsu_wen;
            lsu_addr_q     <= bus.lsu_addr;
            lsu_wdata_q    <= bus.lsu_wdata;
            lsu_wmask_q    <= bus.lsu_wmask;
            lsu_size_q     <= bus.lsu_size;
            last_grant_lsu <= 1'b1;
            state          <= ST_LSU;
          end else if (grant_ifu) begin
            ifu_base       <= bus.ifu_addr;
            ifu_len_q      <= bus.ifu_len;
            beat           <= 2'd0;
            last_grant_lsu <= 1'b0;
            state          <= ST_IFU;
          end
        end
        ST_IFU: begin
          if (bus.mem_respValid) begin
            if (beat == ifu_len_q) begin
              beat  <= 2'd0;
              state <= ST_IDLE;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        ST_LSU: begin
          if (bus.mem_respValid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory-side outputs depend only on registered state, so they are glitch-free
  // and independent of master inputs once granted.
  always_comb begin
    bus.mem_reqValid = 1'b0;
    bus.mem_addr     = 32'd0;
    bus.mem_size     = 2'd0;
    bus.mem_wen      = 1'b0;
    bus.mem_wdata    = 32'd0;
    bus.mem_wmask    = 4'd0;
    bus.ifu_rvalid   = 1'b0;
    bus.ifu_rdata    = 32'd0;
    bus.ifu_rlast    = 1'b0;
    bus.lsu_rvalid   = 1'b0;
    bus.lsu_rdata    = 32'd0;
    case (state)
      ST_IFU: begin
        bus.mem_reqValid = 1'b1;
        bus.mem_addr     = ifu_base + {28'd0, beat, 2'b00};
        bus.mem_size     = 2'b10;
        if (bus.mem_respValid) begin
          bus.ifu_rvalid = 1'b1;
          bus.ifu_rdata  = bus.mem_rdata;
          bus.ifu_rlast  = (beat == ifu_len_q);
        end
      end
      ST_LSU: begin
        bus.mem_reqValid = 1'b1;
        bus.mem_addr     = lsu_addr_q;
        bus.mem_size     = lsu_size_q;
        bus.mem_wen      = lsu_wen_q;
        bus.mem_wdata    = lsu_wdata_q;
        bus.mem_wmask    = lsu_wmask_q;
        if (bus.mem_respValid) begin
          bus.lsu_rvalid = 1'b1;
          bus.lsu_rdata  = bus.mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed bench for ysyx_mem_arbiter: bursts, LSU accesses, tie rotation,
// address wrap, stray responses and mid-burst reset.
module tb_ysyx_mem_arbiter;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  ysyx_mem_arbiter_if bus ();

  ysyx_mem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic check_idle(input string tag);
    settle();
    chk({tag, " reqValid"}, 32'(bus.mem_reqValid), 32'd0);
    chk({tag, " addr"},     bus.mem_addr, 32'd0);
    chk({tag, " wen"},      32'(bus.mem_wen), 32'd0);
    chk({tag, " ifu_rv"},   32'(bus.ifu_rvalid), 32'd0);
    chk({tag, " lsu_rv"},   32'(bus.lsu_rvalid), 32'd0);
  endtask

  task automatic set_ifu(input logic [31:0] addr, input logic [1:0] len);
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = addr;
    bus.ifu_len  = len;
  endtask

  task automatic set_lsu(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [1:0] size);
    bus.lsu_req   = 1'b1;
    bus.lsu_wen   = wen;
    bus.lsu_addr  = addr;
    bus.lsu_wdata = wdata;
    bus.lsu_wmask = wmask;
    bus.lsu_size  = size;
  endtask

  // Dropping req and scrambling fields after the grant must not disturb the transaction.
  task automatic drop_ifu();
    bus.ifu_req  = 1'b0;
    bus.ifu_addr = 32'hBAD0_0000;
    bus.ifu_len  = 2'd1;
  endtask

  task automatic drop_lsu();
    bus.lsu_req   = 1'b0;
    bus.lsu_wen   = ~bus.lsu_wen;
    bus.lsu_addr  = 32'hBAD1_0000;
    bus.lsu_wdata = 32'h0BAD_0BAD;
    bus.lsu_wmask = 4'b1010;
    bus.lsu_size  = 2'b11;
  endtask

  // Called just after the grant edge; runs beats 0..nbeats-1, memory answering
  // one cycle after each request. lsu_req rises at beat lsu_at (if >= 0).
  task automatic ifu_beats(input logic [31:0] base, input int len, input int lsu_at, input int nbeats);
    logic [31:0] ea;
    logic [31:0] ed;
    for (int b = 0; b < nbeats; b++) begin
      ea = base + 32'(b * 4);
      ed = (base + 32'(b)) ^ 32'hA5A5_0000;
      if (b == lsu_at) bus.lsu_req = 1'b1;
      settle();
      chk($sformatf("ifu b%0d reqValid", b), 32'(bus.mem_reqValid), 32'd1);
      chk($sformatf("ifu b%0d addr", b),     bus.mem_addr, ea);
      chk($sformatf("ifu b%0d size", b),     32'(bus.mem_size), 32'd2);
      chk($sformatf("ifu b%0d wen", b),      32'(bus.mem_wen), 32'd0);
      chk($sformatf("ifu b%0d wmask", b),    32'(bus.mem_wmask), 32'd0);
      chk($sformatf("ifu b%0d wdata", b),    bus.mem_wdata, 32'd0);
      chk($sformatf("ifu b%0d early rv", b), 32'(bus.ifu_rvalid), 32'd0);
      tick();
      bus.mem_respValid = 1'b1;
      bus.mem_rdata     = ed;
      settle();
      chk($sformatf("ifu b%0d resp addr", b), bus.mem_addr, ea);
      chk($sformatf("ifu b%0d rvalid", b),    32'(bus.ifu_rvalid), 32'd1);
      chk($sformatf("ifu b%0d rdata", b),     bus.ifu_rdata, ed);
      chk($sformatf("ifu b%0d rlast", b),     32'(bus.ifu_rlast), (b == len) ? 32'd1 : 32'd0);
      chk($sformatf("ifu b%0d lsu_rv", b),    32'(bus.lsu_rvalid), 32'd0);
      chk($sformatf("ifu b%0d lsu_rdata", b), bus.lsu_rdata, 32'd0);
      tick();
      bus.mem_respValid = 1'b0;
      bus.mem_rdata     = 32'd0;
    end
  endtask

  // Called just after the LSU grant edge; holds two cycles without response first.
  task automatic lsu_phase(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input logic [1:0] size, input logic [31:0] rdata);
    for (int c = 0; c < 2; c++) begin
      settle();
      chk($sformatf("lsu c%0d reqValid", c), 32'(bus.mem_reqValid), 32'd1);
      chk($sformatf("lsu c%0d addr", c),     bus.mem_addr, addr);
      chk($sformatf("lsu c%0d wen", c),      32'(bus.mem_wen), 32'(wen));
      chk($sformatf("lsu c%0d wdata", c),    bus.mem_wdata, wdata);
      chk($sformatf("lsu c%0d wmask", c),    32'(bus.mem_wmask), 32'(wmask));
      chk($sformatf("lsu c%0d size", c),     32'(bus.mem_size), 32'(size));
      chk($sformatf("lsu c%0d early rv", c), 32'(bus.lsu_rvalid), 32'd0);
      chk($sformatf("lsu c%0d ifu_rv", c),   32'(bus.ifu_rvalid), 32'd0);
      tick();
    end
    bus.mem_respValid = 1'b1;
    bus.mem_rdata     = rdata;
    settle();
    chk("lsu resp wen",    32'(bus.mem_wen), 32'(wen));
    chk("lsu rvalid",      32'(bus.lsu_rvalid), 32'd1);
    chk("lsu rdata",       bus.lsu_rdata, rdata);
    chk("lsu resp ifu_rv", 32'(bus.ifu_rvalid), 32'd0);
    chk("lsu ifu_rdata",   bus.ifu_rdata, 32'd0);
    tick();
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = 32'd0;
  endtask

  task automatic ifu_start(input logic [31:0] addr, input logic [1:0] len, input string tag);
    set_ifu(addr, len);
    check_idle(tag);
    tick();
    drop_ifu();
  endtask

  task automatic lsu_start(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input logic [1:0] size, input string tag);
    set_lsu(wen, addr, wdata, wmask, size);
    check_idle(tag);
    tick();
    drop_lsu();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.ifu_req = 1'b0; bus.ifu_addr = 32'd0; bus.ifu_len = 2'd0;
    bus.lsu_req = 1'b0; bus.lsu_wen = 1'b0; bus.lsu_addr = 32'd0;
    bus.lsu_wdata = 32'd0; bus.lsu_wmask = 4'd0; bus.lsu_size = 2'd0;
    bus.mem_rdata = 32'd0; bus.mem_respValid = 1'b0;

    // reset state
    check_idle("reset");
    chk("reset size",   32'(bus.mem_size), 32'd0);
    chk("reset wdata",  bus.mem_wdata, 32'd0);
    chk("reset wmask",  32'(bus.mem_wmask), 32'd0);
    chk("reset rlast",  32'(bus.ifu_rlast), 32'd0);
    chk("reset ifu_rd", bus.ifu_rdata, 32'd0);
    chk("reset lsu_rd", bus.lsu_rdata, 32'd0);
    tick();
    reset = 1'b0;

    // first tie after reset goes to LSU; IFU follows after one idle cycle
    set_ifu(32'h2000_0000, 2'd0);
    set_lsu(1'b0, 32'h0000_1000, 32'd0, 4'd0, 2'b10);
    check_idle("tie1 idle");
    tick();
    drop_lsu();
    lsu_phase(1'b0, 32'h0000_1000, 32'd0, 4'd0, 2'b10, 32'h1111_2222);
    check_idle("tie1 gap");
    tick();
    drop_ifu();
    ifu_beats(32'h2000_0000, 0, -1, 1);

    // IFU granted last, so the next tie goes to LSU again (write access)
    set_ifu(32'h2000_0100, 2'd1);
    set_lsu(1'b1, 32'h0F00_0004, 32'hDEAD_BEEF, 4'b0011, 2'b01);
    check_idle("tie2 idle");
    tick();
    drop_lsu();
    lsu_phase(1'b1, 32'h0F00_0004, 32'hDEAD_BEEF, 4'b0011, 2'b01, 32'h5555_AAAA);
    check_idle("tie2 gap");
    tick();
    drop_ifu();
    ifu_beats(32'h2000_0100, 1, -1, 2);

    // LSU alone, then a tie must go to IFU
    lsu_start(1'b0, 32'h0000_2000, 32'h0000_0000, 4'd0, 2'b00, "lsu solo idle");
    lsu_phase(1'b0, 32'h0000_2000, 32'h0000_0000, 4'd0, 2'b00, 32'h0000_00FF);
    set_ifu(32'h2000_0200, 2'd0);
    set_lsu(1'b1, 32'h0000_3000, 32'h1234_5678, 4'b1111, 2'b10);
    check_idle("tie3 idle");
    tick();
    drop_ifu();
    ifu_beats(32'h2000_0200, 0, -1, 1);
    check_idle("tie3 gap");
    tick();
    drop_lsu();
    lsu_phase(1'b1, 32'h0000_3000, 32'h1234_5678, 4'b1111, 2'b10, 32'hCAFE_F00D);

    // four-beat burst
    ifu_start(32'h3000_0010, 2'd3, "burst idle");
    ifu_beats(32'h3000_0010, 3, -1, 4);

    // LSU request arriving mid-burst waits for the last beat
    bus.lsu_wen = 1'b1; bus.lsu_addr = 32'h0000_4000; bus.lsu_wdata = 32'h0A0B_0C0D;
    bus.lsu_wmask = 4'b1100; bus.lsu_size = 2'b01;
    ifu_start(32'h3000_0040, 2'd3, "wait idle");
    ifu_beats(32'h3000_0040, 3, 1, 4);
    check_idle("wait gap");
    tick();
    drop_lsu();
    lsu_phase(1'b1, 32'h0000_4000, 32'h0A0B_0C0D, 4'b1100, 2'b01, 32'h0000_0001);

    // stray response in IDLE, then wrapping burst
    bus.mem_respValid = 1'b1;
    bus.mem_rdata     = 32'h7777_7777;
    settle();
    chk("stray ifu_rv",   32'(bus.ifu_rvalid), 32'd0);
    chk("stray lsu_rv",   32'(bus.lsu_rvalid), 32'd0);
    chk("stray ifu_rd",   bus.ifu_rdata, 32'd0);
    chk("stray lsu_rd",   bus.lsu_rdata, 32'd0);
    chk("stray reqValid", 32'(bus.mem_reqValid), 32'd0);
    tick();
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = 32'd0;
    ifu_start(32'hFFFF_FFF8, 2'd3, "wrap idle");
    ifu_beats(32'hFFFF_FFF8, 3, -1, 4);

    // reset during beat 2 abandons the burst
    ifu_start(32'h3000_0100, 2'd3, "abort idle");
    ifu_beats(32'h3000_0100, 3, -1, 2);
    reset = 1'b1;
    bus.mem_respValid = 1'b1;
    bus.mem_rdata     = 32'h9999_9999;
    settle();
    chk("abort reqValid", 32'(bus.mem_reqValid), 32'd0);
    chk("abort addr",     bus.mem_addr, 32'd0);
    chk("abort size",     32'(bus.mem_size), 32'd0);
    chk("abort ifu_rv",   32'(bus.ifu_rvalid), 32'd0);
    chk("abort rlast",    32'(bus.ifu_rlast), 32'd0);
    chk("abort ifu_rd",   bus.ifu_rdata, 32'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("post abort ifu_rv",   32'(bus.ifu_rvalid), 32'd0);
    chk("post abort reqValid", 32'(bus.mem_reqValid), 32'd0);
    tick();
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = 32'd0;
    check_idle("post abort idle");
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
